// File: rtl/dcache_wr_buffer_pkg.sv
// Shared types and constants for the dcache write buffer.
//   WR_WORD / WR_LINE : entry write-type encodings
//   drain_state_t     : one-hot drain FSM encoding
//   wb_entry_t        : one queued write {typ, addr, size, wstrb, data}
//   line_tag_mask()   : mask keeping only the line-tag bits of an address
package dcache_wr_buffer_pkg;

  localparam logic WR_WORD = 1'b0;
  localparam logic WR_LINE = 1'b1;

  localparam int LINE_OFFSET_BITS_DFLT = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_REQ     = 3'b010,
    S_WAIT_OK = 3'b100
  } drain_state_t;

  typedef struct packed {
    logic         typ;
    logic [31:0]  addr;
    logic [2:0]   size;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wb_entry_t;

  function automatic logic [31:0] line_tag_mask(input int unsigned off);
    logic [31:0] m;
    m = '1;
    return m << off;
  endfunction

endpackage

// File: rtl/dcache_wr_buffer_if.sv
// Bus bundle for the write buffer: dcache push side, bridge data-write side,
// and the read-miss hazard check.
//   slave  : the write buffer
//   master : the surrounding dcache/bridge environment
interface dcache_wr_buffer_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_type;
  logic [31:0]  in_addr;
  logic [2:0]   in_size;
  logic [3:0]   in_wstrb;
  logic [127:0] in_data;

  logic         data_wr_req;
  logic         data_wr_type;
  logic [31:0]  data_wr_addr;
  logic [2:0]   data_wr_size;
  logic [3:0]   data_wr_wstrb;
  logic [127:0] data_wr_data;
  logic         data_wr_rdy;
  logic         data_wr_ok;

  logic [31:0]  rd_chk_addr;
  logic         rd_hit;
  logic         wb_empty;

  modport slave (
    input  in_valid, in_type, in_addr, in_size, in_wstrb, in_data,
    output in_ready,
    output data_wr_req, data_wr_type, data_wr_addr, data_wr_size,
           data_wr_wstrb, data_wr_data,
    input  data_wr_rdy, data_wr_ok,
    input  rd_chk_addr,
    output rd_hit, wb_empty
  );

  modport master (
    output in_valid, in_type, in_addr, in_size, in_wstrb, in_data,
    input  in_ready,
    input  data_wr_req, data_wr_type, data_wr_addr, data_wr_size,
           data_wr_wstrb, data_wr_data,
    output data_wr_rdy, data_wr_ok,
    output rd_chk_addr,
    input  rd_hit, wb_empty
  );
endinterface

// File: rtl/dcache_wr_buffer_fifo_mem.sv
// wb_fifo_mem: DEPTH-entry register array for the write buffer.
//   wr_en/wr_ptr/wr_entry : write one entry and mark it valid
//   clr_en/clr_ptr        : invalidate one entry (pop)
//   rd_ptr/rd_entry       : asynchronous read of one entry (head)
//   chk_addr/tag_hit      : per-entry line-tag compare, not qualified by vld
//   vld                   : per-entry valid bits
module wb_fifo_mem
  import dcache_wr_buffer_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int LINE_OFFSET_BITS = LINE_OFFSET_BITS_DFLT,
  localparam int PW              = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_ptr,
  input  wb_entry_t        wr_entry,
  input  logic             clr_en,
  input  logic [PW-1:0]    clr_ptr,
  input  logic [PW-1:0]    rd_ptr,
  input  logic [31:0]      chk_addr,
  output wb_entry_t        rd_entry,
  output logic [DEPTH-1:0] vld,
  output logic [DEPTH-1:0] tag_hit
);

  localparam logic [31:0] TAG_MASK = line_tag_mask(LINE_OFFSET_BITS);

  wb_entry_t mem [DEPTH];

  // Payload carries no reset; only the valid bits define occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (wr_en && wr_ptr == PW'(i)) mem[i] <= wr_entry;
  end

  // Push and pop never target the same slot: a pop needs count>=1 and a push
  // needs count<DEPTH, so tail != head whenever both fire.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_ptr == PW'(i))       vld[i] <= 1'b1;
        else if (clr_en && clr_ptr == PW'(i)) vld[i] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign tag_hit[g] = ((mem[g].addr ^ chk_addr) & TAG_MASK) == '0;
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/dcache_wr_buffer.sv
// dcache_wr_buffer: in-order write buffer between dcache and the AXI bridge
// data-write port. Holds each entry until the bridge reports completion, and
// flags read misses that hit a line still pending in the buffer.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : push side (in_*), bridge side (data_wr_*), hazard check
//                 (rd_chk_addr -> rd_hit), wb_empty status
module dcache_wr_buffer
  import dcache_wr_buffer_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int LINE_OFFSET_BITS = LINE_OFFSET_BITS_DFLT
) (
  input  logic               clk,
  input  logic               resetn,
  dcache_wr_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [31:0]   TAG_MASK = line_tag_mask(LINE_OFFSET_BITS);

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  drain_state_t     state, state_nxt;
  wb_entry_t        wr_entry, head_entry;
  logic [DEPTH-1:0] vld, tag_hit;
  logic             push, pop, in_hit;

  assign bus.in_ready = (count != FULL);
  assign push = bus.in_valid && bus.in_ready;
  // Completion only counts while a write is actually outstanding.
  assign pop  = (state == S_WAIT_OK) && bus.data_wr_ok;

  assign wr_entry = '{typ:   bus.in_type,
                      addr:  bus.in_addr,
                      size:  bus.in_size,
                      wstrb: bus.in_wstrb,
                      data:  bus.in_data};

  wb_fifo_mem #(
    .DEPTH            (DEPTH),
    .LINE_OFFSET_BITS (LINE_OFFSET_BITS)
  ) u_mem (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (push),
    .wr_ptr   (tail),
    .wr_entry (wr_entry),
    .clr_en   (pop),
    .clr_ptr  (head),
    .rd_ptr   (head),
    .chk_addr (bus.rd_chk_addr),
    .rd_entry (head_entry),
    .vld      (vld),
    .tag_hit  (tag_hit)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // An entry pushed this cycle is the head next cycle, so IDLE may move to
  // REQ on a push even while count is still 0.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (count != '0 || push) state_nxt = S_REQ;
      S_REQ:     if (bus.data_wr_rdy)     state_nxt = S_WAIT_OK;
      S_WAIT_OK: if (bus.data_wr_ok)      state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  assign bus.data_wr_req   = (state == S_REQ);
  assign bus.data_wr_type  = head_entry.typ;
  assign bus.data_wr_addr  = head_entry.addr;
  assign bus.data_wr_size  = head_entry.size;
  assign bus.data_wr_wstrb = head_entry.wstrb;
  assign bus.data_wr_data  = head_entry.data;

  // The incoming write is checked too, so a miss issued in the same cycle as
  // the push cannot slip past it.
  assign in_hit     = push && (((bus.in_addr ^ bus.rd_chk_addr) & TAG_MASK) == '0);
  assign bus.rd_hit = |(vld & tag_hit) || in_hit;

  assign bus.wb_empty = (count == '0) && (state == S_IDLE) && !bus.in_valid;

endmodule
